// File: rtl/cdb_arbiter_if.sv
// Producer handshake and CDB broadcast bundle for cdb_arbiter.
// slave modport: the arbiter. master modport: producers / bus consumers.
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_CDB = 2,
  parameter int TAGW    = 3
);
  logic [NUM_REQ-1:0]      fu_valid;
  logic [NUM_REQ-1:0]      fu_ready;
  logic [NUM_REQ*TAGW-1:0] fu_tag;
  logic [NUM_REQ*32-1:0]   fu_value;
  logic [NUM_REQ*32-1:0]   fu_target_pc;

  logic [NUM_CDB-1:0]      cdb_valid;
  logic [NUM_CDB*TAGW-1:0] cdb_tag;
  logic [NUM_CDB*32-1:0]   cdb_value;
  logic [NUM_CDB*32-1:0]   cdb_target_pc;

  modport master (
    output fu_valid, fu_tag, fu_value, fu_target_pc,
    input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_target_pc
  );

  modport slave (
    input  fu_valid, fu_tag, fu_value, fu_target_pc,
    output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_target_pc
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding register per producer, up to
// NUM_CDB held results granted per cycle onto registered CDB slots.
// Build option: define CDB_ARB_OLDEST_EN for oldest-ROB-entry-first grant
// order (head_ptr used); otherwise round-robin from rr_ptr.
// Tag 0 is reserved: such requests are accepted and dropped.
module cdb_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_CDB     = 2,
  parameter int ROB_ENTRIES = 8,
  parameter int TAGW        = $clog2(ROB_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [TAGW-1:0] head_ptr,
  cdb_arbiter_if.slave    bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] hold_valid_q, hold_valid_d;
  logic [TAGW-1:0]    hold_tag_q   [NUM_REQ];
  logic [TAGW-1:0]    hold_tag_d   [NUM_REQ];
  logic [31:0]        hold_value_q [NUM_REQ];
  logic [31:0]        hold_value_d [NUM_REQ];
  logic [31:0]        hold_pc_q    [NUM_REQ];
  logic [31:0]        hold_pc_d    [NUM_REQ];
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;

  logic [NUM_CDB-1:0]      cdb_valid_q, cdb_valid_d;
  logic [NUM_CDB*TAGW-1:0] cdb_tag_q, cdb_tag_d;
  logic [NUM_CDB*32-1:0]   cdb_value_q, cdb_value_d;
  logic [NUM_CDB*32-1:0]   cdb_pc_q, cdb_pc_d;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_CDB-1:0] slot_v;
  logic [IW-1:0]      slot_idx [NUM_CDB];
  logic               any_grant;
  logic [IW-1:0]      last_idx;

`ifdef CDB_ARB_OLDEST_EN
  logic [IW-1:0] unused_rr;
  assign unused_rr = rr_ptr_q;
`else
  logic unused_head;
  assign unused_head = ^head_ptr;
`endif

  // Pick up to NUM_CDB held entries; the k-th pick drives slot k.
  always_comb begin : p_arb
    int cnt;
    int idx;
    int best;
    int best_age;
    int age [NUM_REQ];
    grant     = '0;
    slot_v    = '0;
    any_grant = 1'b0;
    last_idx  = rr_ptr_q;
    cnt       = 0;
    idx       = 0;
    best      = 0;
    best_age  = 0;
    for (int s = 0; s < NUM_CDB; s++) slot_idx[s] = '0;
    for (int i = 0; i < NUM_REQ; i++) age[i] = 0;
`ifdef CDB_ARB_OLDEST_EN
    // Age is distance from head along the ring 1..ROB_ENTRIES-1 (entry 0 skipped).
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(hold_tag_q[i]) >= int'(head_ptr))
        age[i] = int'(hold_tag_q[i]) - int'(head_ptr);
      else
        age[i] = int'(hold_tag_q[i]) - int'(head_ptr) + (ROB_ENTRIES - 1);
    end
    for (int s = 0; s < NUM_CDB; s++) begin
      best = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
        // Strict compare keeps the lower index on equal age.
        if (hold_valid_q[i] && !grant[i] && (best < 0 || age[i] < best_age)) begin
          best     = i;
          best_age = age[i];
        end
      end
      if (best >= 0) begin
        grant[best] = 1'b1;
        slot_v[s]   = 1'b1;
        slot_idx[s] = IW'(best);
        any_grant   = 1'b1;
        last_idx    = IW'(best);
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (hold_valid_q[idx] && cnt < NUM_CDB) begin
        grant[idx]    = 1'b1;
        slot_v[cnt]   = 1'b1;
        slot_idx[cnt] = IW'(idx);
        any_grant     = 1'b1;
        last_idx      = IW'(idx);
        cnt           = cnt + 1;
      end
    end
`endif
  end

  // A holding register accepts when empty or being drained this cycle.
  always_comb begin
    ready = '0;
    if (rst) ready = ~hold_valid_q | grant;
  end

  assign bus.fu_ready      = ready;
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_tag       = cdb_tag_q;
  assign bus.cdb_value     = cdb_value_q;
  assign bus.cdb_target_pc = cdb_pc_q;

  // Next state for holding registers, CDB slots and round-robin pointer.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_tag_d   = hold_tag_q;
    hold_value_d = hold_value_q;
    hold_pc_d    = hold_pc_q;
    rr_ptr_d     = rr_ptr_q;
    cdb_valid_d  = '0;
    cdb_tag_d    = '0;
    cdb_value_d  = '0;
    cdb_pc_d     = '0;
    if (flush) begin
      hold_valid_d = '0;
      rr_ptr_d     = '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) hold_valid_d[i] = 1'b0;
        if (bus.fu_valid[i] && ready[i]) begin
          hold_valid_d[i] = (bus.fu_tag[i*TAGW +: TAGW] != '0);
          hold_tag_d[i]   = bus.fu_tag[i*TAGW +: TAGW];
          hold_value_d[i] = bus.fu_value[i*32 +: 32];
          hold_pc_d[i]    = bus.fu_target_pc[i*32 +: 32];
        end
      end
      for (int s = 0; s < NUM_CDB; s++) begin
        if (slot_v[s]) begin
          cdb_valid_d[s]             = 1'b1;
          cdb_tag_d[s*TAGW +: TAGW]  = hold_tag_q[slot_idx[s]];
          cdb_value_d[s*32 +: 32]    = hold_value_q[slot_idx[s]];
          cdb_pc_d[s*32 +: 32]       = hold_pc_q[slot_idx[s]];
        end
      end
`ifdef CDB_ARB_OLDEST_EN
      rr_ptr_d = '0;
`else
      if (any_grant) rr_ptr_d = IW'((int'(last_idx) + 1) % NUM_REQ);
`endif
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= '0;
      cdb_tag_q    <= '0;
      cdb_value_q  <= '0;
      cdb_pc_q     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_tag_q[i]   <= '0;
        hold_value_q[i] <= '0;
        hold_pc_q[i]    <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_tag_q   <= hold_tag_d;
      hold_value_q <= hold_value_d;
      hold_pc_q    <= hold_pc_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_value_q  <= cdb_value_d;
      cdb_pc_q     <= cdb_pc_d;
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Schedules functional-unit results onto the common data bus (CDB) consumed by the reorder buffer, reservation stations and load/store queue. Each of NUM_REQ producers (ALU, CMP, LSQ, ...) hands one result at a time into a private one-entry holding register. Every cycle the arbiter grants up to NUM_CDB of the held results onto registered CDB slots. Grant order is round-robin by default, or oldest-ROB-entry-first when the optional feature is compiled in.

Parameters:
NUM_REQ, 4, number of producer ports
NUM_CDB, 2, number of CDB slots per cycle (matches `NUM_CDB_ENTRIES)
ROB_ENTRIES, 8, ROB size (matches `RO_BUFFER_ENTRIES); entry 0 reserved
TAGW, $clog2(ROB_ENTRIES), ROB tag width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset (0 = reset)
flush  input  1  pipeline flush from ROB, synchronous
head_ptr  input  TAGW  ROB head (used only with CDB_ARB_OLDEST_EN)
fu_valid  input  NUM_REQ  producer i presents a result
fu_ready  output  NUM_REQ  holding register i can accept
fu_tag  input  NUM_REQ*TAGW  ROB tag per producer, flattened, producer 0 in LSBs
fu_value  input  NUM_REQ*32  result value per producer
fu_target_pc  input  NUM_REQ*32  branch target per producer
cdb_valid  output  NUM_CDB  slot carries a result
cdb_tag  output  NUM_CDB*TAGW  broadcast tag
cdb_value  output  NUM_CDB*32  broadcast value
cdb_target_pc  output  NUM_CDB*32  broadcast target PC

Behaviour:
- Reset (rst=0, async):
  - holding registers empty
  - rr_ptr=0
  - all cdb_* outputs 0
  - fu_ready=0 while rst is low
- Accept: a transfer happens when fu_valid[i] & fu_ready[i] at a clock edge; the holding register captures tag, value and target_pc.
- fu_ready[i] (combinational) = holding[i] empty OR holding[i] granted this cycle. This gives back-to-back acceptance with no bubble.
- Tag 0 is reserved. A request carrying tag 0 is accepted and discarded, and is never broadcast.
- Arbitration (combinational, over held entries only):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first NUM_CDB valid held entries are granted; the k-th grant goes to slot k.
- CDB outputs are registered: granted entries appear on the cdb_* outputs one cycle after the grant edge.
  - Latency from fu accept edge to cdb_valid high is 2 edges.
  - Each result is broadcast for exactly one cycle.
- Unused slots drive valid=0, tag=0, value=0, target_pc=0. A zero tag is a no-op for ROB matching.
- rr_ptr update: (index of last granted requester + 1) mod NUM_REQ. If nothing is granted, rr_ptr is unchanged.
- Granted holding registers clear at the grant edge unless refilled at the same edge (simultaneous grant+accept → holds the new request).
- Fewer requests than slots: all are granted in the same cycle.
- More requests than slots: losers keep their holding register and fu_ready stays 0 for them. No request waits more than ceil(NUM_REQ/NUM_CDB) cycles.
- Flush (sync, priority over everything except reset):
  - all holding registers clear
  - accepts in the flush cycle are discarded
  - cdb_valid=0 next cycle
  - rr_ptr=0

Optional Feature:
CDB_ARB_OLDEST_EN:
- Defined: grant priority by ROB age, age = tag>=head_ptr ? tag-head_ptr : tag-head_ptr+(ROB_ENTRIES-1). The ring skips entry 0.
  - Smallest age wins; ties go to the lower requester index.
  - rr_ptr is unused and held at 0.
- Undefined: round-robin as above; head_ptr is ignored.

Test Plan:
1. Reset mid-traffic: holding[0]={tag3,val 0x11}, assert rst=0 between edges → cdb_valid=0 and fu_ready=0 immediately. After release, nothing broadcast and rr_ptr=0.
2. Single request: fu_valid[2]=1, tag=5, value=0xDEADBEEF at edge 0 → edge 2 shows cdb_valid=2'b01, slot0 tag 5, value 0xDEADBEEF. One cycle only.
3. Contention: all 4 producers valid (tags 1-4) at the same edge, NUM_CDB=2 → first broadcast tags 1,2, next cycle tags 3,4. fu_ready[2:3]=0 during the first grant cycle. rr_ptr then 0.
4. Back-to-back: producer 1 streams tags 1,2,3 on consecutive edges with no competitors → fu_ready[1] stays 1 and CDB shows 1,2,3 on consecutive cycles.
5. Flush: held tags 4,6 plus a new accept in the flush cycle → no broadcast follows, and the holding registers are empty afterwards.
6. (CDB_ARB_OLDEST_EN) head_ptr=6, ROB_ENTRIES=8, held tags 2,7,6 on producers 0,1,2 → first cycle broadcasts 6 then 7, next cycle 2. Tag-0 request is never broadcast.
